wired_bus_resolver: RTL and testbench

- Parametrised, clocked successor to the single wired-OR net.
- Resolves N_DRV drivers of a WIDTH-bit shared bus per cycle in wired-OR, wired-AND or tri-state mode, and registers the result.
- Reports bus status, per-bit contention and saturating contention statistics.
- Sits between multiple bus masters and a single consumer; replaces ad-hoc wor/wand nets with synthesizable logic.

---
 rtl/wired_bus_resolver_if.sv | 45 ++++
 rtl/wired_bus_resolver.sv | 166 ++++++++++++++++
 tb/tb_wired_bus_resolver.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wired_bus_resolver_if.sv
// Bundle of driver-side inputs and registered resolver outputs for wired_bus_resolver.
// The master modport belongs to whoever drives the bus masters and consumes the result;
// the slave modport belongs to the resolver itself.
interface wired_bus_resolver_if #(
  parameter int WIDTH = 8,
  parameter int N_DRV = 4,
  parameter int CNT_W = 8
);

  logic [N_DRV*WIDTH-1:0] drv_data;
  logic [N_DRV-1:0]       drv_en;
  logic                   clr_stats;

  logic [WIDTH-1:0]       bus_out;
  logic [1:0]             bus_state;
  logic [WIDTH-1:0]       contend_mask;
  logic                   contend_sticky;
  logic [CNT_W-1:0]       multi_cnt;
  logic [CNT_W-1:0]       contend_cnt;

  modport master (
    output drv_data,
    output drv_en,
    output clr_stats,
    input  bus_out,
    input  bus_state,
    input  contend_mask,
    input  contend_sticky,
    input  multi_cnt,
    input  contend_cnt
  );

  modport slave (
    input  drv_data,
    input  drv_en,
    input  clr_stats,
    output bus_out,
    output bus_state,
    output contend_mask,
    output contend_sticky,
    output multi_cnt,
    output contend_cnt
  );

endinterface

// File: rtl/wired_bus_resolver.sv
// wired_bus_resolver: clocked replacement for a wor/wand shared net.
// Resolves N_DRV drivers of a WIDTH-bit bus each cycle in wired-OR (MODE 0),
// wired-AND (MODE 1) or tri-state with contention detection (MODE 2), registers
// the result with one cycle of latency and keeps saturating statistics.
// Optional build macro: BUS_KEEPER_EN -- when defined, FLOAT cycles hold the last
// registered bus value instead of returning to the idle value.
module wired_bus_resolver #(
  parameter int WIDTH = 8,
  parameter int N_DRV = 4,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  wired_bus_resolver_if.slave bus
);

  localparam int EN_W = $clog2(N_DRV + 1);

  // Idle level of the bus: a released wired-AND net floats high, the others low
  localparam logic [WIDTH-1:0] IDLE_VAL = (MODE == 1) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  localparam logic [EN_W-1:0]  EN_ZERO  = '0;
  localparam logic [EN_W-1:0]  EN_ONE   = EN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    FLOAT   = 2'd0,
    DRIVEN  = 2'd1,
    MULTI   = 2'd2,
    CONTEND = 2'd3
  } bus_state_e;

  logic [WIDTH-1:0] or_en;
  logic [WIDTH-1:0] and_en;
  logic [EN_W-1:0]  n_en;

  logic [WIDTH-1:0] contend_nxt;
  logic [WIDTH-1:0] bus_nxt;
  bus_state_e       state_nxt;
  logic             multi_hit;
  logic             contend_hit;

  bus_state_e       state_q;
  logic [WIDTH-1:0] bus_q;
  logic [WIDTH-1:0] mask_q;
  logic             sticky_q;
  logic [CNT_W-1:0] multi_q;
  logic [CNT_W-1:0] contend_q;

  // Fold the enabled drivers into OR/AND reductions and count how many are active
  always_comb begin
    or_en  = '0;
    and_en = '1;
    n_en   = EN_ZERO;
    for (int i = 0; i < N_DRV; i++) begin
      if (bus.drv_en[i]) begin
        or_en  = or_en  | bus.drv_data[i*WIDTH +: WIDTH];
        and_en = and_en & bus.drv_data[i*WIDTH +: WIDTH];
        n_en   = n_en + EN_ONE;
      end
    end
  end

  // Pick the next status, contention bits and resolved bus value
  always_comb begin
    state_nxt   = FLOAT;
    contend_nxt = '0;
    bus_nxt     = IDLE_VAL;

    // Disagreement only means something once two or more drivers are on the bus
    if ((MODE == 2) && (n_en > EN_ONE)) begin
      contend_nxt = or_en ^ and_en;
    end

    if (n_en == EN_ZERO) begin
      state_nxt = FLOAT;
    end else if (n_en == EN_ONE) begin
      state_nxt = DRIVEN;
    end else if (contend_nxt != '0) begin
      state_nxt = CONTEND;
    end else begin
      state_nxt = MULTI;
    end

    if (state_nxt == FLOAT) begin
`ifdef BUS_KEEPER_EN
      bus_nxt = bus_q;
`else
      bus_nxt = IDLE_VAL;
`endif
    end else if (MODE == 1) begin
      bus_nxt = and_en;
    end else begin
      bus_nxt = or_en;
    end
  end

  // Statistics events for the cycle being sampled
  always_comb begin
    multi_hit   = (state_nxt == MULTI) || (state_nxt == CONTEND);
    contend_hit = (state_nxt == CONTEND);
  end

  // Status register; any state may follow any other
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FLOAT;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Registered bus value and contention mask, untouched by clr_stats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_q  <= IDLE_VAL;
      mask_q <= '0;
    end else begin
      bus_q  <= bus_nxt;
      mask_q <= contend_nxt;
    end
  end

  // Sticky contention flag; a clear wins over a same-cycle set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (bus.clr_stats) begin
      sticky_q <= 1'b0;
    end else if (contend_hit) begin
      sticky_q <= 1'b1;
    end
  end

  // Saturating multi-driver counter; a clear wins over a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      multi_q <= '0;
    end else if (bus.clr_stats) begin
      multi_q <= '0;
    end else if (multi_hit && (multi_q != CNT_MAX)) begin
      multi_q <= multi_q + CNT_ONE;
    end
  end

  // Saturating contention counter; a clear wins over a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contend_q <= '0;
    end else if (bus.clr_stats) begin
      contend_q <= '0;
    end else if (contend_hit && (contend_q != CNT_MAX)) begin
      contend_q <= contend_q + CNT_ONE;
    end
  end

  assign bus.bus_out        = bus_q;
  assign bus.bus_state      = state_q;
  assign bus.contend_mask   = mask_q;
  assign bus.contend_sticky = sticky_q;
  assign bus.multi_cnt      = multi_q;
  assign bus.contend_cnt    = contend_q;

endmodule

// File: tb/tb_wired_bus_resolver.sv
// Testbench for wired_bus_resolver: four instances (wired-OR, wired-AND, tri-state,
// and tri-state with 3-bit counters) see identical driver inputs each cycle.
// Expected bus values come from a hand-computed vector table; counters and the
// sticky flag are tracked by a small model and queued as scoreboard entries.
// Honours BUS_KEEPER_EN when it is defined for the build.
module tb_wired_bus_resolver;

  localparam logic [1:0] ST_FLOAT   = 2'd0;
  localparam logic [1:0] ST_DRIVEN  = 2'd1;
  localparam logic [1:0] ST_MULTI   = 2'd2;
  localparam logic [1:0] ST_CONTEND = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // 10 time-unit clock
  always #5 clk = ~clk;

  wired_bus_resolver_if #(.WIDTH(8), .N_DRV(4), .CNT_W(8)) ifc_or  ();
  wired_bus_resolver_if #(.WIDTH(8), .N_DRV(4), .CNT_W(8)) ifc_and ();
  wired_bus_resolver_if #(.WIDTH(8), .N_DRV(4), .CNT_W(8)) ifc_tri ();
  wired_bus_resolver_if #(.WIDTH(8), .N_DRV(4), .CNT_W(3)) ifc_sat ();

  wired_bus_resolver #(.WIDTH(8), .N_DRV(4), .MODE(0), .CNT_W(8)) u_or  (.clk(clk), .rst(rst), .bus(ifc_or));
  wired_bus_resolver #(.WIDTH(8), .N_DRV(4), .MODE(1), .CNT_W(8)) u_and (.clk(clk), .rst(rst), .bus(ifc_and));
  wired_bus_resolver #(.WIDTH(8), .N_DRV(4), .MODE(2), .CNT_W(8)) u_tri (.clk(clk), .rst(rst), .bus(ifc_tri));
  wired_bus_resolver #(.WIDTH(8), .N_DRV(4), .MODE(2), .CNT_W(3)) u_sat (.clk(clk), .rst(rst), .bus(ifc_sat));

  typedef struct {
    logic [3:0]  en;
    logic [31:0] data;
    logic        clr;
    logic [7:0]  or_bus;
    logic [7:0]  and_bus;
    logic [7:0]  tri_bus;
    logic [7:0]  mask;
    logic [1:0]  st_plain;
    logic [1:0]  st_tri;
  } vec_t;

  typedef struct {
    logic [7:0] or_bus;
    logic [7:0] and_bus;
    logic [7:0] tri_bus;
    logic [7:0] mask;
    logic [1:0] st_plain;
    logic [1:0] st_tri;
    logic [7:0] multi8;
    logic [7:0] cont8;
    logic [2:0] multi3;
    logic [2:0] cont3;
    logic       sticky;
  } exp_t;

  vec_t vecs [12];
  exp_t sb [$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_multi8;
  logic [7:0] m_cont8;
  logic [2:0] m_multi3;
  logic [2:0] m_cont3;
  logic       m_sticky;
  logic [7:0] last_or;
  logic [7:0] last_and;
  logic [7:0] last_tri;

  function automatic vec_t mkVec(input logic [3:0] en, input logic [31:0] data, input logic clr,
                                 input logic [7:0] or_bus, input logic [7:0] and_bus,
                                 input logic [7:0] tri_bus, input logic [7:0] mask,
                                 input logic [1:0] st_plain, input logic [1:0] st_tri);
    vec_t v;
    v.en = en; v.data = data; v.clr = clr;
    v.or_bus = or_bus; v.and_bus = and_bus; v.tri_bus = tri_bus; v.mask = mask;
    v.st_plain = st_plain; v.st_tri = st_tri;
    return v;
  endfunction

  task automatic resetModel();
    m_multi8 = 8'd0; m_cont8 = 8'd0;
    m_multi3 = 3'd0; m_cont3 = 3'd0;
    m_sticky = 1'b0;
    last_or = 8'h00; last_and = 8'hFF; last_tri = 8'h00;
  endtask

  task automatic driveAll(input logic [3:0] en, input logic [31:0] data, input logic clr);
    ifc_or.drv_en  = en; ifc_or.drv_data  = data; ifc_or.clr_stats  = clr;
    ifc_and.drv_en = en; ifc_and.drv_data = data; ifc_and.clr_stats = clr;
    ifc_tri.drv_en = en; ifc_tri.drv_data = data; ifc_tri.clr_stats = clr;
    ifc_sat.drv_en = en; ifc_sat.drv_data = data; ifc_sat.clr_stats = clr;
  endtask

  task automatic compareField(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    driveAll(v.en, v.data, v.clr);
    e.or_bus  = v.or_bus;
    e.and_bus = v.and_bus;
    e.tri_bus = v.tri_bus;
`ifdef BUS_KEEPER_EN
    if (v.en == 4'b0000) begin
      e.or_bus  = last_or;
      e.and_bus = last_and;
      e.tri_bus = last_tri;
    end
`endif
    last_or  = e.or_bus;
    last_and = e.and_bus;
    last_tri = e.tri_bus;
    e.mask     = v.mask;
    e.st_plain = v.st_plain;
    e.st_tri   = v.st_tri;
    if (v.clr) begin
      m_multi8 = 8'd0; m_cont8 = 8'd0;
      m_multi3 = 3'd0; m_cont3 = 3'd0;
      m_sticky = 1'b0;
    end else begin
      if (v.st_plain == ST_MULTI) begin
        if (m_multi8 != 8'hFF) m_multi8 = m_multi8 + 8'd1;
        if (m_multi3 != 3'h7)  m_multi3 = m_multi3 + 3'd1;
      end
      if (v.st_tri == ST_CONTEND) begin
        if (m_cont8 != 8'hFF) m_cont8 = m_cont8 + 8'd1;
        if (m_cont3 != 3'h7)  m_cont3 = m_cont3 + 3'd1;
        m_sticky = 1'b1;
      end
    end
    e.multi8 = m_multi8; e.cont8 = m_cont8;
    e.multi3 = m_multi3; e.cont3 = m_cont3;
    e.sticky = m_sticky;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard: got 0 queued entries, expected at least 1");
      return;
    end
    e = sb.pop_front();
    compareField("or.bus_out",         ifc_or.bus_out,             e.or_bus);
    compareField("or.bus_state",       8'(ifc_or.bus_state),       8'(e.st_plain));
    compareField("or.contend_mask",    ifc_or.contend_mask,        8'h00);
    compareField("or.multi_cnt",       ifc_or.multi_cnt,           e.multi8);
    compareField("or.contend_cnt",     ifc_or.contend_cnt,         8'h00);
    compareField("or.contend_sticky",  8'(ifc_or.contend_sticky),  8'h00);
    compareField("and.bus_out",        ifc_and.bus_out,            e.and_bus);
    compareField("and.bus_state",      8'(ifc_and.bus_state),      8'(e.st_plain));
    compareField("and.contend_mask",   ifc_and.contend_mask,       8'h00);
    compareField("and.multi_cnt",      ifc_and.multi_cnt,          e.multi8);
    compareField("and.contend_cnt",    ifc_and.contend_cnt,        8'h00);
    compareField("tri.bus_out",        ifc_tri.bus_out,            e.tri_bus);
    compareField("tri.bus_state",      8'(ifc_tri.bus_state),      8'(e.st_tri));
    compareField("tri.contend_mask",   ifc_tri.contend_mask,       e.mask);
    compareField("tri.multi_cnt",      ifc_tri.multi_cnt,          e.multi8);
    compareField("tri.contend_cnt",    ifc_tri.contend_cnt,        e.cont8);
    compareField("tri.contend_sticky", 8'(ifc_tri.contend_sticky), 8'(e.sticky));
    compareField("sat.bus_out",        ifc_sat.bus_out,            e.tri_bus);
    compareField("sat.multi_cnt",      8'(ifc_sat.multi_cnt),      8'(e.multi3));
    compareField("sat.contend_cnt",    8'(ifc_sat.contend_cnt),    8'(e.cont3));
    compareField("sat.contend_sticky", 8'(ifc_sat.contend_sticky), 8'(e.sticky));
  endtask

  task automatic checkReset(input string tag);
    compareField({tag, " or.bus_out"},        ifc_or.bus_out,             8'h00);
    compareField({tag, " and.bus_out"},       ifc_and.bus_out,            8'hFF);
    compareField({tag, " tri.bus_out"},       ifc_tri.bus_out,            8'h00);
    compareField({tag, " or.bus_state"},      8'(ifc_or.bus_state),       8'(ST_FLOAT));
    compareField({tag, " and.bus_state"},     8'(ifc_and.bus_state),      8'(ST_FLOAT));
    compareField({tag, " tri.bus_state"},     8'(ifc_tri.bus_state),      8'(ST_FLOAT));
    compareField({tag, " tri.contend_mask"},  ifc_tri.contend_mask,       8'h00);
    compareField({tag, " tri.contend_sticky"},8'(ifc_tri.contend_sticky), 8'h00);
    compareField({tag, " tri.multi_cnt"},     ifc_tri.multi_cnt,          8'h00);
    compareField({tag, " tri.contend_cnt"},   ifc_tri.contend_cnt,        8'h00);
    compareField({tag, " sat.multi_cnt"},     8'(ifc_sat.multi_cnt),      8'h00);
    compareField({tag, " sat.contend_cnt"},   8'(ifc_sat.contend_cnt),    8'h00);
  endtask

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, vector table, saturation, clear, mid-run reset
  initial begin
    //                en       data           clr   or     and    tri    mask   plain      tri-state
    vecs[0]  = mkVec(4'b0011, 32'h0000_F00F, 1'b0, 8'hFF, 8'h00, 8'hFF, 8'hFF, ST_MULTI,  ST_CONTEND);
    vecs[1]  = mkVec(4'b0101, 32'h553F_AAFC, 1'b0, 8'hFF, 8'h3C, 8'hFF, 8'hC3, ST_MULTI,  ST_CONTEND);
    vecs[2]  = mkVec(4'b0000, 32'hFFFF_FFFF, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, ST_FLOAT,  ST_FLOAT);
    vecs[3]  = mkVec(4'b1001, 32'hA4FF_FFA5, 1'b0, 8'hA5, 8'hA4, 8'hA5, 8'h01, ST_MULTI,  ST_CONTEND);
    vecs[4]  = mkVec(4'b1000, 32'hA4FF_FFA5, 1'b0, 8'hA4, 8'hA4, 8'hA4, 8'h00, ST_DRIVEN, ST_DRIVEN);
    vecs[5]  = mkVec(4'b0110, 32'h003C_3CFF, 1'b0, 8'h3C, 8'h3C, 8'h3C, 8'h00, ST_MULTI,  ST_MULTI);
    vecs[6]  = mkVec(4'b1111, 32'h8181_8181, 1'b0, 8'h81, 8'h81, 8'h81, 8'h00, ST_MULTI,  ST_MULTI);
    vecs[7]  = mkVec(4'b0001, 32'hFFFF_FF5A, 1'b0, 8'h5A, 8'h5A, 8'h5A, 8'h00, ST_DRIVEN, ST_DRIVEN);
    vecs[8]  = mkVec(4'b0000, 32'h0000_0000, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, ST_FLOAT,  ST_FLOAT);
    vecs[9]  = mkVec(4'b1111, 32'h0804_0201, 1'b0, 8'h0F, 8'h00, 8'h0F, 8'h0F, ST_MULTI,  ST_CONTEND);
    vecs[10] = mkVec(4'b1111, 32'h0804_0201, 1'b1, 8'h0F, 8'h00, 8'h0F, 8'h0F, ST_MULTI,  ST_CONTEND);
    vecs[11] = mkVec(4'b0010, 32'h0000_7700, 1'b0, 8'h77, 8'h77, 8'h77, 8'h00, ST_DRIVEN, ST_DRIVEN);

    resetModel();
    driveAll(4'b0000, 32'h0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkReset("por");
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput();
    end

    // Hold contention long enough to pin the 3-bit counters at 7
    for (int k = 0; k < 10; k++) begin
      applyStimulus(vecs[9]);
      @(negedge clk);
      checkOutput();
    end

    // Clear arriving together with contention must win
    applyStimulus(vecs[10]);
    @(negedge clk);
    checkOutput();

    // Reset asserted between edges while contention is registered
    applyStimulus(vecs[9]);
    @(posedge clk);
    #1;
    checkOutput();
    #2;
    rst = 1'b1;
    #1;
    checkReset("async");
    @(negedge clk);
    rst = 1'b0;
    resetModel();
    applyStimulus(vecs[9]);
    @(negedge clk);
    checkOutput();

    applyStimulus(vecs[11]);
    @(negedge clk);
    checkOutput();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
